// File: rtl/match_event_logger_if.sv
// rtl/match_event_logger_if.sv - match pulse input, clear and timestamp read-stream bundle
interface match_event_logger_if #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             y;
    logic             clr;
    logic             rd_ready;
    logic             rd_valid;
    logic [TS_W-1:0]  rd_data;
    logic [CNT_W-1:0] match_count;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

    modport master (
        input  y, clr, rd_ready,
        output rd_valid, rd_data, match_count, fifo_level, overflow
    );

    modport slave (
        output y, clr, rd_ready,
        input  rd_valid, rd_data, match_count, fifo_level, overflow
    );
endinterface

// File: rtl/match_event_logger.sv
// rtl/match_event_logger.sv - timestamps 1001-detector match pulses into a small FIFO
// with a saturating match counter and a sticky overflow flag.
module match_event_logger #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    match_event_logger_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             valid_q, valid_d;
    logic [TS_W-1:0]  head_q, head_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [TS_W-1:0]  mem_d [DEPTH];

    logic          full;
    logic          pop;
    logic          push_ok;
    logic [AW-1:0] rd_next;

    always_comb begin
        ts_d     = ts_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        valid_d  = valid_q;
        head_d   = head_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;

        full    = (level_q == LW'(DEPTH));
        pop     = valid_q && bus.rd_ready;
        push_ok = bus.y && (!full || pop);
        rd_next = rd_ptr_q + 1'b1;

        if (bus.clr) begin
            ts_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
            head_d   = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            ts_d = ts_q + 1'b1;

            if (push_ok) begin
                mem_d[wr_ptr_q] = ts_q;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (bus.y && !push_ok) begin
                ovf_d = 1'b1;
            end
            if (bus.y && (count_q != '1)) begin
                count_d = count_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_next;
            end

            level_d = level_q + LW'(push_ok) - LW'(pop);
            valid_d = (level_d != '0);

            // The head register tracks the entry at rd_ptr so rd_data never comes from the RAM read mux.
            if (push_ok && ((level_q == '0) || (pop && (level_q == LW'(1))))) begin
                head_d = ts_q;
            end else if (pop && (level_q > LW'(1))) begin
                head_d = mem_q[rd_next];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.rd_valid    = valid_q;
    assign bus.rd_data     = head_q;
    assign bus.match_count = count_q;
    assign bus.fifo_level  = level_q;
    assign bus.overflow    = ovf_q;
endmodule
